// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe datapath: mark codes, board geometry
// and the board-controller game state.
package ttt_pkg;

   localparam logic [1:0] EMPTY  = 2'b00;
   localparam logic [1:0] MARK_X = 2'b01;
   localparam logic [1:0] MARK_O = 2'b10;

   localparam int N_TILES = 9;
   localparam int TILE_W  = 2;

   typedef enum logic [1:0] {
      PLAY = 2'd0,
      FULL = 2'd1,
      OVER = 2'd2
   } game_state_t;

   function automatic logic [1:0] other_mark(input logic [1:0] mark);
      return (mark == MARK_X) ? MARK_O : MARK_X;
   endfunction

endpackage

// File: rtl/move_hist_stack.sv
// Move-history LIFO: one tile index per accepted move, popped by undo.
// Top-of-stack is read combinationally so undo can clear its tile on the same edge.
module move_hist_stack
   import ttt_pkg::*;
#(
   parameter int DEPTH = N_TILES,
   parameter int W     = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] top,
   output logic         empty,
   output logic         full
);

   localparam int PW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_reg [DEPTH];
   logic [PW-1:0] ptr_reg;
   logic [PW-1:0] top_idx;

   assign empty   = (ptr_reg == '0);
   assign full    = (ptr_reg == PW'(DEPTH));
   assign top_idx = ptr_reg - 1'b1;
   assign top     = empty ? '0 : mem_reg[top_idx];

   // Storage carries no reset; only entries below the pointer are ever read.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem_reg[ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_reg <= '0;
      end else if (push && !full) begin
         ptr_reg <= ptr_reg + 1'b1;
      end else if (pop && !empty) begin
         ptr_reg <= ptr_reg - 1'b1;
      end
   end

endmodule

// File: rtl/board_ctrl.sv
// Tic-tac-toe board writer: legality check, board register, turn order,
// game-state FSM and undo via the move-history stack.
module board_ctrl
   import ttt_pkg::*;
#(
   parameter logic [1:0] FIRST_PLAYER = 2'b01,
   parameter bit         UNDO_EN      = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        move_valid,
   input  logic [3:0]  move_idx,
   input  logic        undo_req,
   input  logic        game_over,
   output logic [17:0] tiles,
   output logic [1:0]  cur_player,
   output logic        move_ack,
   output logic        move_reject,
   output logic        undo_sig,
   output logic [3:0]  move_count,
   output logic        board_full
);

   game_state_t state_reg, state_next;
   logic [1:0]  board_reg [N_TILES];
   logic [1:0]  player_reg;
   logic [3:0]  count_reg, count_next;
   logic        full_reg;
   logic        ack_reg, reject_reg, undo_sig_reg;

   logic [N_TILES-1:0] target_hit;
   logic [3:0] hist_top;
   logic       hist_empty, hist_full;
   logic       undo_req_eff, undo_acc, move_acc, idx_ok;

   assign undo_req_eff = UNDO_EN && undo_req;
   assign undo_acc     = undo_req_eff && !hist_empty;
   assign idx_ok       = (move_idx <= 4'(N_TILES - 1));
   assign move_acc     = move_valid && (state_reg == PLAY) && !game_over && idx_ok
                         && !(|target_hit) && !undo_req_eff && !hist_full;

   move_hist_stack #(.DEPTH(N_TILES), .W(4)) u_hist (
      .clk       (clk),
      .reset     (reset),
      .push      (move_acc),
      .pop       (undo_acc),
      .push_data (move_idx),
      .top       (hist_top),
      .empty     (hist_empty),
      .full      (hist_full)
   );

   // One register per tile; a move writes the addressed tile, an undo clears the popped one.
   generate
      for (genvar gi = 0; gi < N_TILES; gi++) begin : g_tile
         assign target_hit[gi] = (move_idx == 4'(gi)) && (board_reg[gi] != EMPTY);
         assign tiles[gi*TILE_W +: TILE_W] = board_reg[gi];

         always_ff @(posedge clk) begin
            if (reset) begin
               board_reg[gi] <= EMPTY;
            end else if (move_acc && (move_idx == 4'(gi))) begin
               board_reg[gi] <= player_reg;
            end else if (undo_acc && (hist_top == 4'(gi))) begin
               board_reg[gi] <= EMPTY;
            end
         end
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      if (move_acc) begin
         count_next = count_reg + 1'b1;
      end else if (undo_acc) begin
         count_next = count_reg - 1'b1;
      end

      // A live game_over always lands in OVER; only an undo with it low leaves OVER.
      if (undo_acc) begin
         state_next = game_over ? OVER : PLAY;
      end else if (game_over) begin
         state_next = OVER;
      end else if (move_acc && (count_next == 4'(N_TILES))) begin
         state_next = FULL;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= PLAY;
         player_reg   <= FIRST_PLAYER;
         count_reg    <= '0;
         full_reg     <= 1'b0;
         ack_reg      <= 1'b0;
         reject_reg   <= 1'b0;
         undo_sig_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         count_reg    <= count_next;
         full_reg     <= (count_next == 4'(N_TILES));
         ack_reg      <= move_acc;
         reject_reg   <= move_valid && !move_acc;
         undo_sig_reg <= undo_acc;
         if (move_acc || undo_acc) begin
            player_reg <= other_mark(player_reg);
         end
      end
   end

   assign cur_player  = player_reg;
   assign move_count  = count_reg;
   assign board_full  = full_reg;
   assign move_ack    = ack_reg;
   assign move_reject = reject_reg;
   assign undo_sig    = undo_sig_reg;

endmodule

// File: tb/tb_board_ctrl.sv
// Directed, table-driven bench for board_ctrl with hand-computed expectations.
module tb_board_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        move_valid;
   logic [3:0]  move_idx;
   logic        undo_req;
   logic        game_over;
   logic [17:0] tiles;
   logic [1:0]  cur_player;
   logic        move_ack;
   logic        move_reject;
   logic        undo_sig;
   logic [3:0]  move_count;
   logic        board_full;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   board_ctrl #(.FIRST_PLAYER(2'b01), .UNDO_EN(1'b1)) dut (
      .clk         (clk),
      .reset       (reset),
      .move_valid  (move_valid),
      .move_idx    (move_idx),
      .undo_req    (undo_req),
      .game_over   (game_over),
      .tiles       (tiles),
      .cur_player  (cur_player),
      .move_ack    (move_ack),
      .move_reject (move_reject),
      .undo_sig    (undo_sig),
      .move_count  (move_count),
      .board_full  (board_full)
   );

   typedef struct {
      logic        mv;
      logic [3:0]  idx;
      logic        undo;
      logic        go;
      logic        ack;
      logic        rej;
      logic        usig;
      logic [17:0] tl;
      logic [1:0]  pl;
      logic [3:0]  cnt;
      logic        full;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic mv, logic [3:0] idx, logic undo, logic go,
                               logic ack, logic rej, logic usig, logic [17:0] tl,
                               logic [1:0] pl, logic [3:0] cnt, logic full);
      vec_t v;
      v.mv = mv; v.idx = idx; v.undo = undo; v.go = go;
      v.ack = ack; v.rej = rej; v.usig = usig; v.tl = tl;
      v.pl = pl; v.cnt = cnt; v.full = full;
      return v;
   endfunction

   task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic ack, input logic rej, input logic usig,
                            input logic [17:0] tl, input logic [1:0] pl,
                            input logic [3:0] cnt, input logic full);
      check({tag, " move_ack"},    18'(move_ack),    18'(ack));
      check({tag, " move_reject"}, 18'(move_reject), 18'(rej));
      check({tag, " undo_sig"},    18'(undo_sig),    18'(usig));
      check({tag, " tiles"},       tiles,            tl);
      check({tag, " cur_player"},  18'(cur_player),  18'(pl));
      check({tag, " move_count"},  18'(move_count),  18'(cnt));
      check({tag, " board_full"},  18'(board_full),  18'(full));
   endtask

   task automatic drive(input logic rst, input logic mv, input logic [3:0] idx,
                        input logic undo, input logic go);
      @(negedge clk);
      reset = rst; move_valid = mv; move_idx = idx; undo_req = undo; game_over = go;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; move_valid = 1'b0; move_idx = 4'd0; undo_req = 1'b0; game_over = 1'b0;

      //           mv idx   un go  ack rej us  tiles     pl  cnt full
      vecs.push_back(mk(1, 4'd4,  0, 0, 1, 0, 0, 18'h00100, 2, 1, 0)); // first move X@4
      vecs.push_back(mk(1, 4'd4,  0, 0, 0, 1, 0, 18'h00100, 2, 1, 0)); // occupied
      vecs.push_back(mk(1, 4'd9,  0, 0, 0, 1, 0, 18'h00100, 2, 1, 0)); // idx 9
      vecs.push_back(mk(1, 4'd15, 0, 0, 0, 1, 0, 18'h00100, 2, 1, 0)); // idx 15
      vecs.push_back(mk(0, 4'd0,  1, 0, 0, 0, 1, 18'h00000, 1, 0, 0)); // undo
      vecs.push_back(mk(0, 4'd0,  1, 0, 0, 0, 0, 18'h00000, 1, 0, 0)); // undo, empty history
      vecs.push_back(mk(1, 4'd0,  0, 0, 1, 0, 0, 18'h00001, 2, 1, 0));
      vecs.push_back(mk(1, 4'd0,  0, 0, 0, 1, 0, 18'h00001, 2, 1, 0));
      vecs.push_back(mk(1, 4'd4,  0, 0, 1, 0, 0, 18'h00201, 1, 2, 0));
      vecs.push_back(mk(1, 4'd8,  0, 0, 1, 0, 0, 18'h10201, 2, 3, 0));
      vecs.push_back(mk(0, 4'd0,  1, 0, 0, 0, 1, 18'h00201, 1, 2, 0)); // undo clears tile 8
      vecs.push_back(mk(0, 4'd0,  0, 0, 0, 0, 0, 18'h00201, 1, 2, 0)); // idle
      vecs.push_back(mk(1, 4'd1,  0, 0, 1, 0, 0, 18'h00205, 2, 3, 0));
      vecs.push_back(mk(1, 4'd2,  0, 0, 1, 0, 0, 18'h00225, 1, 4, 0));
      vecs.push_back(mk(1, 4'd6,  0, 0, 1, 0, 0, 18'h01225, 2, 5, 0));
      vecs.push_back(mk(0, 4'd0,  0, 1, 0, 0, 0, 18'h01225, 2, 5, 0)); // game over
      vecs.push_back(mk(1, 4'd2,  0, 1, 0, 1, 0, 18'h01225, 2, 5, 0));
      vecs.push_back(mk(1, 4'd3,  0, 1, 0, 1, 0, 18'h01225, 2, 5, 0));
      vecs.push_back(mk(1, 4'd3,  0, 0, 0, 1, 0, 18'h01225, 2, 5, 0)); // still OVER
      vecs.push_back(mk(0, 4'd0,  1, 0, 0, 0, 1, 18'h00225, 1, 4, 0)); // undo -> PLAY
      vecs.push_back(mk(1, 4'd3,  0, 0, 1, 0, 0, 18'h00265, 2, 5, 0));
      vecs.push_back(mk(1, 4'd5,  0, 0, 1, 0, 0, 18'h00A65, 1, 6, 0));
      vecs.push_back(mk(1, 4'd6,  0, 0, 1, 0, 0, 18'h01A65, 2, 7, 0));
      vecs.push_back(mk(1, 4'd7,  0, 0, 1, 0, 0, 18'h09A65, 1, 8, 0));
      vecs.push_back(mk(1, 4'd8,  0, 0, 1, 0, 0, 18'h19A65, 2, 9, 1)); // board full
      vecs.push_back(mk(1, 4'd0,  0, 0, 0, 1, 0, 18'h19A65, 2, 9, 1)); // 10th move
      vecs.push_back(mk(1, 4'd9,  0, 0, 0, 1, 0, 18'h19A65, 2, 9, 1));
      vecs.push_back(mk(1, 4'd8,  1, 0, 0, 1, 1, 18'h09A65, 1, 8, 0)); // undo beats move
      vecs.push_back(mk(1, 4'd8,  0, 0, 1, 0, 0, 18'h19A65, 2, 9, 1));
      vecs.push_back(mk(0, 4'd0,  1, 1, 0, 0, 1, 18'h09A65, 1, 8, 0)); // undo, game_over high
      vecs.push_back(mk(1, 4'd8,  0, 0, 0, 1, 0, 18'h09A65, 1, 8, 0)); // stays OVER
      vecs.push_back(mk(0, 4'd0,  1, 0, 0, 0, 1, 18'h01A65, 2, 7, 0));
      vecs.push_back(mk(1, 4'd7,  0, 0, 1, 0, 0, 18'h09A65, 1, 8, 0));

      drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      check_all("reset", 0, 0, 0, 18'h00000, 2'b01, 4'd0, 0);
      $display("reset: tiles=%h player=%b count=%0d", tiles, cur_player, move_count);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(1'b0, vecs[i].mv, vecs[i].idx, vecs[i].undo, vecs[i].go);
         check_all($sformatf("vec%0d", i), vecs[i].ack, vecs[i].rej, vecs[i].usig,
                   vecs[i].tl, vecs[i].pl, vecs[i].cnt, vecs[i].full);
         $display("vec %0d: mv=%b idx=%0d undo=%b go=%b -> ack=%b rej=%b usig=%b tiles=%h pl=%b cnt=%0d full=%b",
                  i, vecs[i].mv, vecs[i].idx, vecs[i].undo, vecs[i].go, move_ack, move_reject,
                  undo_sig, tiles, cur_player, move_count, board_full);
      end

      // Reset mid-game with live requests: board clears, no pulses.
      drive(1'b1, 1'b1, 4'd8, 1'b1, 1'b0);
      check_all("midreset", 0, 0, 0, 18'h00000, 2'b01, 4'd0, 0);
      $display("mid-game reset: tiles=%h ack=%b rej=%b usig=%b", tiles, move_ack, move_reject, undo_sig);

      // History pointer must also be cleared: one move, one undo, then undo finds nothing.
      drive(1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
      check_all("post_reset_move", 1, 0, 0, 18'h00100, 2'b10, 4'd1, 0);
      $display("post-reset move idx 4: ack=%b tiles=%h", move_ack, tiles);
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      check_all("post_reset_undo", 0, 0, 1, 18'h00000, 2'b01, 4'd0, 0);
      $display("post-reset undo: usig=%b tiles=%h", undo_sig, tiles);
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      check_all("post_reset_undo_empty", 0, 0, 0, 18'h00000, 2'b01, 4'd0, 0);
      $display("post-reset undo on empty history: usig=%b tiles=%h", undo_sig, tiles);

      drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
